// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner.
// Key numbering is row*4 + col throughout.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KEYS = 16;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } lowest_t;

    function automatic logic [3:0] key_index(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return {row, col};
    endfunction

    // Priority pick of the lowest-numbered set bit
    function automatic lowest_t lowest_set(input logic [KEYS-1:0] v);
        lowest_t r;
        r.valid = 1'b0;
        r.idx   = 4'd0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Column slot timer: divides the system clock into column slots
// and steps the active column, flagging the end of each full scan.
module scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [1:0] col,
    output logic       scan_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick      = (cnt == CW'(SCAN_DIV - 1));
    assign scan_done = tick && (col == 2'd3);

    // Slot counter, wraps at the end of each column slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Active column advances once per slot, 3 wraps to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= 2'd0;
        end else if (tick) begin
            col <= col + 2'd1;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner/debouncer producing a clean held-key vector.
// Build option: KEYPAD_CHORD_EN exposes the full debounced vector on buttons.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] buttons,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_press
);

    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

    logic            tick;
    logic            scan_done;
    logic [1:0]      col;
    logic [3:0]      row_s1;
    logic [3:0]      row_s2;
    logic [KEYS-1:0] snap;
    logic [KEYS-1:0] snap_next;
    logic [KEYS-1:0] prev_snap;
    logic [KEYS-1:0] debounced;
    logic [SW-1:0]   stable_cnt;
    logic [SW-1:0]   stable_next;
    logic            prev_valid;
    logic [3:0]      prev_code;
    lowest_t         lo;

    scan_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .col      (col),
        .scan_done(scan_done)
    );

    assign col_out = ~(4'b0001 << col);

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= 4'b1111;
            row_s2 <= 4'b1111;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    // Snapshot with the current column's rows merged in (pressed = 1)
    always_comb begin
        snap_next = snap;
        for (int r = 0; r < ROWS; r++) begin
            snap_next[key_index(2'(r), col)] = ~row_s2[r];
        end
    end

    // Stability count for the scan that is just completing
    always_comb begin
        if (snap_next != prev_snap) begin
            stable_next = '0;
        end else if (stable_cnt == SW'(DEBOUNCE_SCANS)) begin
            stable_next = stable_cnt;
        end else begin
            stable_next = stable_cnt + SW'(1);
        end
    end

    // Capture rows of the active column at the end of its slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap <= '0;
        end else if (tick) begin
            snap <= snap_next;
        end
    end

    // Debounce across full scans; commit once stable long enough
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_snap  <= '0;
            stable_cnt <= '0;
            debounced  <= '0;
        end else if (scan_done) begin
            prev_snap  <= snap_next;
            stable_cnt <= stable_next;
            if (stable_next == SW'(DEBOUNCE_SCANS)) begin
                debounced <= snap_next;
            end
        end
    end

    assign lo        = lowest_set(debounced);
    assign key_valid = lo.valid;
    assign key_code  = lo.idx;

`ifdef KEYPAD_CHORD_EN
    assign buttons = debounced;
`else
    assign buttons = lo.valid ? (16'b1 << lo.idx) : 16'b0;
`endif

    // Remember last cycle's resolved key to detect new presses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_code  <= 4'd0;
        end else begin
            prev_valid <= key_valid;
            prev_code  <= key_code;
        end
    end

    assign key_press = key_valid &&
                       (!prev_valid || (key_code != prev_code));

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized bench for keypad_scan with a scan-level reference model.
// Keypad matrix is modelled as a 16-bit set of pressed keys.
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] buttons;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_press;

    logic [15:0] keys = 16'h0;

    int vectors     = 0;
    int miscompares = 0;
    int presses     = 0;

    // Reference model state
    int          m = 0;
    logic [15:0] h1 = 0, h2 = 0, snap = 0, deb = 0;
    logic [15:0] scans[$];
    logic        pv = 0;
    logic [3:0]  pc = 0;

    keypad_scan #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .buttons  (buttons),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_press(key_press)
    );

    always #5 clk = ~clk;

    // Physical matrix: a row reads low if a pressed key joins it to the driven column
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
        end
    end

    function automatic logic [4:0] low(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return {1'b1, 4'(i)};
        end
        return 5'd0;
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s: got %h expected %h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // One clock of the model: key (r,c) is seen when column c's slot ends,
    // using the key state from two clocks earlier; commit needs DB+1 equal scans.
    task automatic model_step();
        logic [4:0] lo;
        int n, c;
        bit same;
        if (rst) begin
            m = 0; h1 = 0; h2 = 0; snap = 0; deb = 0;
            scans = {16'h0};
            pv = 0; pc = 0;
            return;
        end
        lo = low(deb);
        pv = lo[4];
        pc = lo[3:0];
        n = m;
        c = (n / SD) % 4;
        if (n % SD == SD - 1) begin
            for (int r = 0; r < 4; r++) snap[r*4 + c] = h2[r*4 + c];
            if (c == 3) begin
                scans.push_back(snap);
                if (scans.size() > DB + 1) void'(scans.pop_front());
                same = (scans.size() == DB + 1);
                foreach (scans[i]) if (scans[i] != snap) same = 0;
                if (same) deb = snap;
            end
        end
        h2 = h1;
        h1 = keys;
        m++;
    endtask

    initial begin
        scans = {16'h0};
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Every-cycle comparison against the model
    initial begin
        logic [4:0]  lo;
        logic [15:0] eb;
        logic [3:0]  ecol;
        logic        ep;
        forever begin
            @(negedge clk);
            if (key_press === 1'b1) presses++;
            if (rst) begin
                check("rst_col", 16'(col_out), 16'hE);
                check("rst_buttons", buttons, 16'h0);
                check("rst_valid", 16'(key_valid), 16'h0);
                check("rst_code", 16'(key_code), 16'h0);
                check("rst_press", 16'(key_press), 16'h0);
            end else begin
                lo = low(deb);
`ifdef KEYPAD_CHORD_EN
                eb = deb;
`else
                eb = lo[4] ? (16'h1 << lo[3:0]) : 16'h0;
`endif
                ep   = lo[4] && (!pv || lo[3:0] != pc);
                ecol = ~(4'b0001 << ((m / SD) % 4));
                check("col_out", 16'(col_out), 16'(ecol));
                check("buttons", buttons, eb);
                check("key_valid", 16'(key_valid), 16'(lo[4]));
                check("key_code", 16'(key_code), 16'(lo[3:0]));
                check("key_press", 16'(key_press), 16'(ep));
            end
        end
    end

    task automatic wait_buttons(input string name, input logic [15:0] b,
                                input int budget, output int took);
        took = 0;
        while (buttons !== b && took < budget) begin
            @(negedge clk);
            took++;
        end
        check(name, buttons, b);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int took;
        logic [15:0] chord_exp;

        cycles(3);
        check("lit_rst_col", 16'(col_out), 16'hE);
        check("lit_rst_buttons", buttons, 16'h0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Column walk after reset release
        @(negedge clk);
        cycles(3);
        check("lit_col1", 16'(col_out), 16'hD);
        cycles(4);
        check("lit_col2", 16'(col_out), 16'hB);
        cycles(4);
        check("lit_col3", 16'(col_out), 16'h7);
        cycles(4);
        check("lit_col0", 16'(col_out), 16'hE);

        // Steady key 9 press and release
        cycles(70);
        presses = 0;
        keys = 16'h1 << 9;
        wait_buttons("lit_k9_commit", 16'h0200, 83, took);
        check("lit_k9_code", 16'(key_code), 16'd9);
        check("lit_k9_valid", 16'(key_valid), 16'd1);
        cycles(40);
        check("lit_k9_one_press", 16'(presses), 16'd1);
        keys = 16'h0;
        wait_buttons("lit_k9_release", 16'h0000, 83, took);
        cycles(20);
        check("lit_k9_release_nopress", 16'(presses), 16'd1);

        // Bouncing key 9, then steady
        presses = 0;
        for (int i = 0; i < 10; i++) begin
            keys = keys ^ (16'h1 << 9);
            cycles(10);
        end
        check("lit_bounce_nopress", 16'(presses), 16'd0);
        check("lit_bounce_invalid", 16'(key_valid), 16'd0);
        keys = 16'h1 << 9;
        took = 0;
        while (presses == 0 && took < 90) begin
            @(negedge clk);
            took++;
        end
        check("lit_bounce_press", 16'(presses), 16'd1);
        check("lit_bounce_latency", 16'(took >= 3 * 4 * SD), 16'd1);
        keys = 16'h0;
        wait_buttons("lit_bounce_release", 16'h0000, 83, took);

        // Keys 3 and 12 together
`ifdef KEYPAD_CHORD_EN
        chord_exp = 16'h1008;
`else
        chord_exp = 16'h0008;
`endif
        keys = 16'h1008;
        wait_buttons("lit_chord", chord_exp, 83, took);
        check("lit_chord_code", 16'(key_code), 16'd3);
        keys = 16'h0;
        wait_buttons("lit_chord_release", 16'h0000, 83, took);

        // Key 4 switched straight to key 5
        presses = 0;
        keys = 16'h0010;
        wait_buttons("lit_k4", 16'h0010, 83, took);
        keys = 16'h0020;
        wait_buttons("lit_k5", 16'h0020, 83, took);
        cycles(2);
        check("lit_k4k5_presses", 16'(presses), 16'd2);
        keys = 16'h0;
        wait_buttons("lit_k5_release", 16'h0000, 83, took);

        // Reset in the middle of a held key
        keys = 16'h1 << 9;
        wait_buttons("lit_pre_rst", 16'h0200, 83, took);
        cycles(5);
        presses = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("lit_async_buttons", buttons, 16'h0);
        check("lit_async_valid", 16'(key_valid), 16'd0);
        check("lit_async_col", 16'(col_out), 16'hE);
        cycles(3);
        #2 rst = 1'b0;
        wait_buttons("lit_recommit", 16'h0200, 83, took);
        check("lit_recommit_full", 16'(took >= 4 * 4 * SD - 4), 16'd1);
        cycles(2);
        check("lit_recommit_press", 16'(presses), 16'd1);

        // Randomized key patterns with occasional reset pulses
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: keys = 16'h0;
                1: keys = 16'h1 << $urandom_range(0, 15);
                2: keys = (16'h1 << $urandom_range(0, 15)) |
                          (16'h1 << $urandom_range(0, 15));
                default: keys = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) begin
                cycles($urandom_range(1, 40));
                #($urandom_range(1, 4)) rst = 1'b1;
                cycles($urandom_range(1, 3));
                #2 rst = 1'b0;
            end
            cycles($urandom_range(10, 120));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

4x4 matrix keypad scanner and debouncer feeding the tone generator's `buttons[15:0]` input. Drives one keypad column low at a time, samples the four row lines, debounces the full 16-key snapshot across consecutive scans, and presents a clean held-key vector plus a one-cycle press event. Sits between the board keypad pins and the beep/tone stage, running on the 50 MHz system clock.

## Interface
- `SCAN_DIV`, 50000: clocks per column slot (1 ms at 50 MHz); legal range ≥ 4.
- `DEBOUNCE_SCANS`, 5: consecutive identical full scans required before commit; legal range ≥ 1.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `row_in`  in  4  keypad rows, active-low (pulled up externally), asynchronous to `clk`.
- `col_out`  out  4  keypad column drive, active-low, exactly one bit low at all times.
- `buttons`  out  16  debounced held keys; bit index = row*4 + col.
- `key_valid`  out  1  high while any committed key is held.
- `key_code`  out  4  index of the lowest-numbered committed key; 0 when none.
- `key_press`  out  1  single-cycle pulse when the committed lowest key changes to a new pressed key.

## Operation
- `row_in` passes through a 2-flop synchronizer (reset value 4'b1111) before any use.
- Slot counter counts 0..SCAN_DIV-1; `tick` asserts on count SCAN_DIV-1. Column index `col` (0..3) advances on `tick`, wrapping 3→0; `col_out` = ~(1<<col).
- On `tick`, synchronized rows are inverted and written into snapshot bits {row*4+col} for the current column. On the tick ending column 3 the scan is complete.
- At scan completion: if snapshot == previous snapshot, `stable_cnt` increments (saturates at DEBOUNCE_SCANS); otherwise `stable_cnt` clears to 0. Previous snapshot ← snapshot.
- Commit: when `stable_cnt` reaches DEBOUNCE_SCANS, debounced vector ← snapshot. Commit repeats harmlessly while stable.
- Output resolve (default build): `buttons` = one-hot of lowest set bit of debounced vector, 0 if none. `key_code` = that index; `key_valid` = |debounced.
- `key_press` = 1 for one clock when `key_valid` is 1 and (`key_valid` was 0 or `key_code` differs from its previous committed value). Release never pulses.
- Reset (any time, including mid-scan/mid-hold): `col_out`=4'b1110, `buttons`=0, `key_valid`=0, `key_code`=0, `key_press`=0; all counters, snapshots and synchronizer cleared. Held keys must re-debounce fully after reset deasserts.

## Timing
- Full scan = 4*SCAN_DIV clocks. Row settle per column = SCAN_DIV-1 clocks (≥ 3 including synchronizer).
- Key stable from start of scan k is committed at end of scan k+DEBOUNCE_SCANS; `buttons`, `key_valid`, `key_code` update on the clock after that final tick; `key_press` asserts in that same cycle.
- Worst-case press/release latency: (DEBOUNCE_SCANS+2)*4*SCAN_DIV + 3 clocks.
- Any snapshot difference restarts debounce; bounces shorter than one scan may be missed entirely (acceptable).
- Simultaneous change of keys in one scan is treated as one new snapshot.

## Configuration
- `KEYPAD_CHORD_EN`: when defined, `buttons` = full debounced vector (multiple bits allowed); `key_code`, `key_valid`, `key_press` unchanged (lowest-key based). When undefined, `buttons` is one-hot or zero (safe for single-tone consumer).

## Structure
- Package `keypad_pkg`: constants ROWS=4, COLS=4, KEYS=16; function `key_index(row,col)`; function `lowest_set(logic [15:0])` returning index and valid.
- One sub-module: `scan_tick` (slot counter + column counter, outputs `tick`, `col`, `scan_done`).

## Test plan
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan = 16 clocks).
- Reset asserted → `col_out`=4'b1110, `buttons`=16'h0000, `key_valid`=0, `key_press`=0; after release `col_out` steps 1110→1101→1011→0111 every 4 clocks.
- Model key 9 (row 2 low while `col_out[1]` low) held steady → within 83 clocks `buttons`=16'h0200, `key_code`=9, `key_valid`=1, exactly one `key_press` pulse; release → `buttons`=0 within 83 clocks, no pulse.
- Key 9 bouncing (toggle every 10 clocks for 100 clocks) then steady → no commit during bounce; single `key_press` ≥ 3 stable scans after bounce ends.
- Keys 3 and 12 held → `buttons`=16'h0008, `key_code`=3; with `KEYPAD_CHORD_EN` → `buttons`=16'h1008, `key_code`=3.
- Key 4 held then switched directly to key 5 in one scan → `buttons` 16'h0010→16'h0020, second `key_press` pulse.
- `rst` pulsed mid-hold of key 9 → outputs 0 immediately (async); after release re-commit with new `key_press` after full debounce.
